// File: rtl/kamacore_dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder slice.
// Optional misaligned-access checking is enabled by defining KAMACORE_DMEM_ALIGN_CHECK_EN.
package kamacore_dmem_responder_pkg;

   localparam int CPU_WIDTH  = 32;
   localparam int DMEM_LANES = CPU_WIDTH / 8;

   typedef enum logic [1:0] {
      DMEM_IDLE,
      DMEM_WAIT,
      DMEM_RESP
   } dmem_state_t;

   // A load always needs an aligned address; a store only when it touches a lane.
   function automatic logic dmem_misaligned(input logic [1:0] addr_lsbs,
                                            input logic we,
                                            input logic [DMEM_LANES-1:0] be);
      return (addr_lsbs != 2'b00) && (!we || (be != '0));
   endfunction

endpackage

// File: rtl/kamacore_dmem_responder_if.sv
// Data-memory request/response bundle between the MEM stage (master) and the responder (slave).
// Both channels use valid/ready: a transfer happens at a rising edge where valid and ready are both high.
interface kamacore_dmem_responder_if
   import kamacore_dmem_responder_pkg::*;
#(
   parameter int ADDR_WIDTH = 12
) ();

   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [CPU_WIDTH-1:0]  req_wdata;
   logic [DMEM_LANES-1:0] req_be;
   logic                  resp_valid;
   logic                  resp_ready;
   logic [CPU_WIDTH-1:0]  resp_rdata;
   logic                  resp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );

endinterface

// File: rtl/kamacore_dmem_responder_array.sv
// Single-port word RAM with byte-lane writes and a registered read port.
// The read register only updates on an enabled load, so it holds the last load result.
module kamacore_dmem_array
   import kamacore_dmem_responder_pkg::*;
#(
   parameter int IDX_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  en,
   input  logic                  we,
   input  logic [DMEM_LANES-1:0] be,
   input  logic [IDX_WIDTH-1:0]  idx,
   input  logic [CPU_WIDTH-1:0]  wdata,
   output logic [CPU_WIDTH-1:0]  rdata
);

   logic [CPU_WIDTH-1:0] mem [2**IDX_WIDTH];

   always_ff @(posedge clk) begin
      if (en && we) begin
         for (int i = 0; i < DMEM_LANES; i++) begin
            if (be[i]) begin
               mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
      end
      if (en && !we) begin
         rdata <= mem[idx];
      end
   end

endmodule

// File: rtl/kamacore_dmem_responder.sv
// Data-memory responder: accepts one request, waits WAIT_CYCLES, accesses the array, then answers.
// Define KAMACORE_DMEM_ALIGN_CHECK_EN to reject misaligned accesses with resp_err.
module kamacore_dmem_responder
   import kamacore_dmem_responder_pkg::*;
#(
   parameter int ADDR_WIDTH  = 12,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                            clk,
   input  logic                            rst,
   kamacore_dmem_responder_if.slave        bus,
   output dmem_state_t                     dbg_state
);

   localparam int IDX_WIDTH = ADDR_WIDTH - 2;

   dmem_state_t           state;
   logic [3:0]            cnt;
   logic                  we_q;
   logic [IDX_WIDTH-1:0]  idx_q;
   logic [CPU_WIDTH-1:0]  wdata_q;
   logic [DMEM_LANES-1:0] be_q;
   logic                  err_q;
   logic                  rd_sel;
   logic                  access_err;
   logic                  access_fire;
   logic [CPU_WIDTH-1:0]  arr_rdata;

`ifdef KAMACORE_DMEM_ALIGN_CHECK_EN
   logic misalign_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         misalign_q <= 1'b0;
      end else if (state == DMEM_IDLE && bus.req_valid) begin
         misalign_q <= dmem_misaligned(bus.req_addr[1:0], bus.req_we, bus.req_be);
      end
   end

   assign access_err = misalign_q;
`else
   logic unused_addr_lsbs;
   assign unused_addr_lsbs = ^bus.req_addr[1:0];
   assign access_err       = 1'b0;
`endif

   // The access edge is the WAIT edge with cnt==0; a reset on that edge cancels the access.
   assign access_fire = (state == DMEM_WAIT) && (cnt == 4'd0) && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= DMEM_IDLE;
         cnt    <= 4'd0;
         err_q  <= 1'b0;
         rd_sel <= 1'b0;
      end else begin
         case (state)
            DMEM_IDLE: begin
               if (bus.req_valid) begin
                  we_q    <= bus.req_we;
                  idx_q   <= bus.req_addr[ADDR_WIDTH-1:2];
                  wdata_q <= bus.req_wdata;
                  be_q    <= bus.req_be;
                  cnt     <= 4'(WAIT_CYCLES);
                  state   <= DMEM_WAIT;
               end
            end
            DMEM_WAIT: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  err_q  <= access_err;
                  rd_sel <= !we_q && !access_err;
                  state  <= DMEM_RESP;
               end
            end
            DMEM_RESP: begin
               if (bus.resp_ready) begin
                  err_q  <= 1'b0;
                  rd_sel <= 1'b0;
                  state  <= DMEM_IDLE;
               end
            end
            default: begin
               state <= DMEM_IDLE;
            end
         endcase
      end
   end

   kamacore_dmem_array #(
      .IDX_WIDTH (IDX_WIDTH)
   ) u_array (
      .clk   (clk),
      .en    (access_fire && !access_err),
      .we    (we_q),
      .be    (be_q),
      .idx   (idx_q),
      .wdata (wdata_q),
      .rdata (arr_rdata)
   );

   // The array's read register is the response data register; rd_sel zeroes it for stores/errors.
   assign bus.req_ready  = (state == DMEM_IDLE) && !rst;
   assign bus.resp_valid = (state == DMEM_RESP);
   assign bus.resp_rdata = rd_sel ? arr_rdata : '0;
   assign bus.resp_err   = err_q;
   assign dbg_state      = state;

endmodule

// File: tb/tb_kamacore_dmem_responder.sv
// Directed bench for kamacore_dmem_responder: one instance with WAIT_CYCLES=2, one with WAIT_CYCLES=0.
// Expected values follow KAMACORE_DMEM_ALIGN_CHECK_EN when it is defined for the build.
module tb_kamacore_dmem_responder;
   import kamacore_dmem_responder_pkg::*;

   typedef struct {
      logic        we;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   dmem_state_t dbg_a;
   dmem_state_t dbg_b;

   int          n_total = 0;
   int          n_pass  = 0;
   logic [31:0] exp_q[$];
   vec_t        vecs[16];
   int          n_vec;
   logic [31:0] w10_exp;

   kamacore_dmem_responder_if #(.ADDR_WIDTH(12)) bus_a ();
   kamacore_dmem_responder_if #(.ADDR_WIDTH(12)) bus_b ();

   kamacore_dmem_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(2)) dut_a (
      .clk(clk), .rst(rst), .bus(bus_a), .dbg_state(dbg_a)
   );
   kamacore_dmem_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(0)) dut_b (
      .clk(clk), .rst(rst), .bus(bus_b), .dbg_state(dbg_b)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic vec_t mk(input logic we, input logic [11:0] addr, input logic [31:0] wdata,
                               input logic [3:0] be, input logic [31:0] exp_rdata, input logic exp_err);
      vec_t v;
      v.we = we; v.addr = addr; v.wdata = wdata; v.be = be;
      v.exp_rdata = exp_rdata; v.exp_err = exp_err;
      return v;
   endfunction

   // Issue one request on bus_a; returns the response seen and the cycles from acceptance to resp_valid.
   task automatic xact(input logic we, input logic [11:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input bit release_resp,
                       output logic [31:0] rdata, output logic err, output int lat, output bit ok);
      int waits;
      ok = 1'b0; lat = 0; rdata = '0; err = 1'b0; waits = 0;
      bus_a.req_we = we; bus_a.req_addr = addr; bus_a.req_wdata = wdata; bus_a.req_be = be;
      bus_a.req_valid = 1'b1;
      while (!bus_a.req_ready && waits < 20) begin
         @(posedge clk); #1; waits++;
      end
      if (!bus_a.req_ready) begin
         bus_a.req_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      bus_a.req_valid = 1'b0;
      bus_a.req_wdata = ~wdata; bus_a.req_addr = addr ^ 12'h040; bus_a.req_be = ~be; bus_a.req_we = ~we;
      while (!bus_a.resp_valid && lat < 20) begin
         @(posedge clk); #1; lat++;
      end
      ok = bus_a.resp_valid;
      rdata = bus_a.resp_rdata;
      err = bus_a.resp_err;
      if (ok && release_resp) begin
         bus_a.resp_ready = 1'b1;
         @(posedge clk); #1;
         bus_a.resp_ready = 1'b0;
      end
   endtask

   initial begin
      logic [31:0] rd;
      logic [31:0] held;
      logic        er;
      int          lat;
      bit          ok;
      int          acc_e[$];
      int          rv_e[$];

      bus_a.req_valid = 0; bus_a.req_we = 0; bus_a.req_addr = 0; bus_a.req_wdata = 0;
      bus_a.req_be = 0; bus_a.resp_ready = 0;
      bus_b.req_valid = 0; bus_b.req_we = 0; bus_b.req_addr = 0; bus_b.req_wdata = 0;
      bus_b.req_be = 0; bus_b.resp_ready = 0;

      n_vec = 0;
      vecs[n_vec++] = mk(1, 12'h010, 32'hDEADBEEF, 4'hF, 32'h0, 0);
      vecs[n_vec++] = mk(0, 12'h010, 32'h0,        4'h0, 32'hDEADBEEF, 0);
      vecs[n_vec++] = mk(1, 12'h010, 32'h000000AA, 4'h1, 32'h0, 0);
      vecs[n_vec++] = mk(0, 12'h010, 32'h0,        4'hF, 32'hDEADBEAA, 0);
      vecs[n_vec++] = mk(1, 12'h024, 32'hCAFEF00D, 4'hF, 32'h0, 0);
      vecs[n_vec++] = mk(1, 12'h024, 32'h11223344, 4'h6, 32'h0, 0);
      vecs[n_vec++] = mk(0, 12'h024, 32'h0,        4'h0, 32'hCA22330D, 0);
      vecs[n_vec++] = mk(1, 12'h024, 32'hFFFFFFFF, 4'h0, 32'h0, 0);
      vecs[n_vec++] = mk(0, 12'h024, 32'h0,        4'h0, 32'hCA22330D, 0);
      vecs[n_vec++] = mk(1, 12'hFFC, 32'h55AA55AA, 4'hF, 32'h0, 0);
      vecs[n_vec++] = mk(0, 12'hFFC, 32'h0,        4'h0, 32'h55AA55AA, 0);
      vecs[n_vec++] = mk(1, 12'h010, 32'hBB000000, 4'h8, 32'h0, 0);
`ifdef KAMACORE_DMEM_ALIGN_CHECK_EN
      vecs[n_vec++] = mk(0, 12'h013, 32'h0,        4'h0, 32'h0, 1);
      vecs[n_vec++] = mk(1, 12'h011, 32'h01020304, 4'hF, 32'h0, 1);
      vecs[n_vec++] = mk(0, 12'h010, 32'h0,        4'h0, 32'hBBADBEAA, 0);
      w10_exp = 32'hBBADBEAA;
`else
      vecs[n_vec++] = mk(0, 12'h013, 32'h0,        4'h0, 32'hBBADBEAA, 0);
      vecs[n_vec++] = mk(1, 12'h011, 32'h01020304, 4'hF, 32'h0, 0);
      vecs[n_vec++] = mk(0, 12'h010, 32'h0,        4'h0, 32'h01020304, 0);
      w10_exp = 32'h01020304;
`endif
      vecs[n_vec++] = mk(1, 12'h012, 32'h77777777, 4'h0, 32'h0, 0);

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_req_ready", 32'(bus_a.req_ready), 32'd0);
      check("rst_resp_valid", 32'(bus_a.resp_valid), 32'd0);
      check("rst_resp_rdata", bus_a.resp_rdata, 32'd0);
      check("rst_resp_err", 32'(bus_a.resp_err), 32'd0);
      rst = 1'b0;
      #1;
      check("post_rst_req_ready", 32'(bus_a.req_ready), 32'd1);
      @(posedge clk); #1;
      check("post_rst_req_ready_b", 32'(bus_b.req_ready), 32'd1);
      check("post_rst_resp_valid", 32'(bus_a.resp_valid), 32'd0);

      // Table-driven transactions on the WAIT_CYCLES=2 instance
      for (int i = 0; i < n_vec; i++) begin
         exp_q.push_back(vecs[i].exp_rdata);
         xact(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, 1'b1, rd, er, lat, ok);
         check($sformatf("v%0d_resp_seen", i), 32'(ok), 32'd1);
         check($sformatf("v%0d_latency", i), 32'(lat), 32'd3);
         check($sformatf("v%0d_rdata", i), rd, exp_q.pop_front());
         check($sformatf("v%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      end

      // Stall in RESP with a competing request that must be ignored
      xact(1'b0, 12'h010, 32'h0, 4'h0, 1'b0, rd, er, lat, ok);
      check("stall_resp_seen", 32'(ok), 32'd1);
      check("stall_rdata", rd, w10_exp);
      held = rd;
      bus_a.req_valid = 1'b1; bus_a.req_we = 1'b1; bus_a.req_addr = 12'h010;
      bus_a.req_wdata = 32'hFFFFFFFF; bus_a.req_be = 4'hF;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         check($sformatf("stall%0d_resp_valid", c), 32'(bus_a.resp_valid), 32'd1);
         check($sformatf("stall%0d_rdata", c), bus_a.resp_rdata, held);
         check($sformatf("stall%0d_req_ready", c), 32'(bus_a.req_ready), 32'd0);
         check($sformatf("stall%0d_state", c), 32'(dbg_a), 32'(DMEM_RESP));
      end
      bus_a.req_valid = 1'b0;
      bus_a.resp_ready = 1'b1;
      @(posedge clk); #1;
      bus_a.resp_ready = 1'b0;
      check("stall_release_resp_valid", 32'(bus_a.resp_valid), 32'd0);
      check("stall_release_req_ready", 32'(bus_a.req_ready), 32'd1);
      xact(1'b0, 12'h010, 32'h0, 4'h0, 1'b1, rd, er, lat, ok);
      check("stall_ignored_store", rd, w10_exp);

      // WAIT_CYCLES=0: back-to-back loads with resp_ready held high
      bus_b.resp_ready = 1'b1; bus_b.req_we = 1'b0; bus_b.req_addr = 12'h000; bus_b.req_valid = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         logic rdy;
         rdy = bus_b.req_ready;
         @(posedge clk); #1;
         if (rdy) acc_e.push_back(c);
         if (bus_b.resp_valid) rv_e.push_back(c);
      end
      bus_b.req_valid = 1'b0;
      bus_b.resp_ready = 1'b0;
      check("b2b_accept_count", 32'(acc_e.size()), 32'd4);
      check("b2b_valid_count", 32'(rv_e.size()), 32'd4);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("b2b_accept%0d_edge", k), 32'(k < acc_e.size() ? acc_e[k] : -1), 32'(1 + 3*k));
         check($sformatf("b2b_valid%0d_edge", k), 32'(k < rv_e.size() ? rv_e[k] : -1), 32'(2 + 3*k));
      end

      // Store discarded by a reset pulse before its access edge
      xact(1'b1, 12'h030, 32'hA5A5A5A5, 4'hF, 1'b1, rd, er, lat, ok);
      check("pre_rst_store_seen", 32'(ok), 32'd1);
      bus_a.req_we = 1'b1; bus_a.req_addr = 12'h030; bus_a.req_wdata = 32'h12345678;
      bus_a.req_be = 4'hF; bus_a.req_valid = 1'b1;
      @(posedge clk); #1;
      check("discard_accepted_state", 32'(dbg_a), 32'(DMEM_WAIT));
      bus_a.req_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("discard_rst_req_ready", 32'(bus_a.req_ready), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         check($sformatf("discard%0d_resp_valid", c), 32'(bus_a.resp_valid), 32'd0);
      end
      xact(1'b0, 12'h030, 32'h0, 4'h0, 1'b1, rd, er, lat, ok);
      check("discard_load_seen", 32'(ok), 32'd1);
      check("discard_old_data", rd, 32'hA5A5A5A5);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
